// File: rtl/bram_tree_pq.sv
// bram_tree_pq: max-priority binary heap; levels 0-1 in registers, each deeper level in its own block RAM.
// o_data always shows the root; one enqueue/dequeue/replace is accepted per IDLE period.
module bram_tree_pq #(
   parameter int QUEUE_SIZE = 15,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  i_wrt,
   input  logic                  i_read,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DATA_WIDTH-1:0] o_data
);
   localparam int L  = $clog2(QUEUE_SIZE + 1);
   localparam int LW = $clog2(L);
   localparam int OW = L - 1;
   typedef enum logic [2:0] {IDLE, DQ_WT, SD_RL, SD_RR, SD_CMP, SU_RD, SU_CMP} state_t;
   state_t state, state_nx;
   logic [L-1:0] size;
   logic [LW-1:0] pl, pn, pp, lv_e, lv_d, al, bl;
   logic [OW-1:0] pk, c, ra, of_e, of_d, ak, bk;
   logic [DATA_WIDTH-1:0] root, cur, lq, big, pv, ad, bd;
   logic ae, be, do_enq, do_deq, do_rep, l_ok, r_ok, rgt, sd_swap, su_swap;
   logic we [L];
   logic [OW-1:0] wa [L];
   logic [DATA_WIDTH-1:0] wd [L], rdv [L];

   function automatic logic [LW-1:0] lv(input int n);
      lv = '0;
      for (int i = 1; i < L; i++) if (n + 1 >= (1 << i)) lv = LW'(i);
   endfunction

   function automatic logic [OW-1:0] off(input int n);
      return OW'(n + 1 - (1 << lv(n)));
   endfunction

   assign o_empty = size == '0;
   assign o_full  = size == L'(QUEUE_SIZE);
   assign o_data  = o_empty ? '0 : root;
   assign do_enq  = i_wrt && (!i_read || o_empty) && !o_full;
   assign do_deq  = i_read && !i_wrt && !o_empty;
   assign do_rep  = i_read && i_wrt && !o_empty;
   assign lv_e    = lv(int'(size));
   assign of_e    = off(int'(size));
   assign lv_d    = lv(int'(size) - 1);
   assign of_d    = off(int'(size) - 1);
   assign pn      = pl + LW'(1);
   assign pp      = pl - LW'(1);
   // (pl,pk) is where cur currently sits; children live one level down at 2k/2k+1
   assign l_ok    = ((2 << pl) - 1 + 2 * int'(pk)) < int'(size);
   assign r_ok    = ((2 << pl) + 2 * int'(pk)) < int'(size);
   assign rgt     = r_ok && (rdv[pn] > lq);
   assign big     = rgt ? rdv[pn] : lq;
   assign c       = {pk[OW-2:0], rgt};
   assign sd_swap = big > cur;
   assign pv      = rdv[pp];
   assign su_swap = cur > pv;

   always_ff @(posedge CLK)
      if (RSTn) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:   state_nx = do_enq ? (lv_e == '0 ? IDLE : SU_RD) :
                            do_deq ? (size == L'(1) ? IDLE : DQ_WT) :
                            do_rep ? SD_RL : IDLE;
         DQ_WT:  state_nx = SD_RL;
         SD_RL:  state_nx = (pl == LW'(L - 1) || !l_ok) ? IDLE : SD_RR;
         SD_RR:  state_nx = SD_CMP;
         SD_CMP: state_nx = sd_swap ? SD_RL : IDLE;
         SU_RD:  state_nx = SU_CMP;
         SU_CMP: state_nx = (su_swap && pl > LW'(1)) ? SU_RD : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ae = 1'b0;
      al = '0;
      ak = '0;
      ad = '0;
      be = 1'b0;
      bl = '0;
      bk = '0;
      bd = '0;
      ra = '0;
      case (state)
         IDLE: begin
            ae = do_enq || do_rep;
            al = do_enq ? lv_e : '0;
            ak = do_enq ? of_e : '0;
            ad = i_data;
            ra = of_d;
         end
         DQ_WT: begin
            ae = 1'b1;
            ad = rdv[pl];
         end
         SD_RL: ra = {pk[OW-2:0], 1'b0};
         SD_RR: ra = {pk[OW-2:0], 1'b1};
         SD_CMP: begin
            ae = sd_swap;
            al = pl;
            ak = pk;
            ad = big;
            be = sd_swap;
            bl = pn;
            bk = c;
            bd = cur;
         end
         SU_RD: ra = pk >> 1;
         SU_CMP: begin
            ae = su_swap;
            al = pl;
            ak = pk;
            ad = pv;
            be = su_swap;
            bl = pp;
            bk = pk >> 1;
            bd = cur;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK)
      if (RSTn) begin
         size <= '0;
         pl   <= '0;
         pk   <= '0;
         cur  <= '0;
         lq   <= '0;
         root <= '0;
      end else begin
         if (we[0]) root <= wd[0];
         case (state)
            IDLE: begin
               size <= do_enq ? size + L'(1) : do_deq ? size - L'(1) : size;
               pl   <= do_enq ? lv_e : do_deq ? lv_d : '0;
               pk   <= do_enq ? of_e : do_deq ? of_d : '0;
               cur  <= i_data;
            end
            DQ_WT: begin
               cur <= rdv[pl];
               pl  <= '0;
               pk  <= '0;
            end
            SD_RR: lq <= rdv[pn];
            SD_CMP: if (sd_swap) begin
               pl <= pn;
               pk <= c;
            end
            SU_CMP: if (su_swap) begin
               pl <= pp;
               pk <= pk >> 1;
            end
            default: ;
         endcase
      end

   // two write requests (a, b) fan out to the per-level write ports; a swap never hits one level twice
   for (genvar g = 0; g < L; g++) begin : wp
      logic a_hit;
      assign a_hit = ae && al == LW'(g);
      assign we[g] = a_hit || (be && bl == LW'(g));
      assign wa[g] = a_hit ? ak : bk;
      assign wd[g] = a_hit ? ad : bd;
   end

   assign rdv[0] = root;

   for (genvar g = 1; g < L; g++) begin : lvl
      logic [DATA_WIDTH-1:0] mem [2**g];
      logic [DATA_WIDTH-1:0] rq;
      if (g < 2) begin : regs
         always_ff @(posedge CLK)
            if (RSTn) mem <= '{default: '0};
            else if (we[g]) mem[wa[g][g-1:0]] <= wd[g];
      end else begin : ram
         always_ff @(posedge CLK)
            if (we[g]) mem[wa[g][g-1:0]] <= wd[g];
      end
      always_ff @(posedge CLK) rq <= mem[ra[g-1:0]];
      assign rdv[g] = rq;
   end
endmodule

// File: tb/tb_bram_tree_pq.sv
// tb_bram_tree_pq: directed enqueue/dequeue/replace sequences on bram_tree_pq with a multiset model for random phases.
module tb_bram_tree_pq;
   localparam int QS = 15;
   localparam int DW = 16;
   logic CLK = 1'b0, RSTn = 1'b1, i_wrt = 1'b0, i_read = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic o_full, o_empty;
   logic [DW-1:0] o_data;
   int vectors = 0, miscompares = 0;
   int unsigned mq[$];
   logic [DW-1:0] keys [15]    = '{5, 900, 17, 900, 1024, 300, 42, 7, 2000, 64, 512, 1, 900, 33, 128};
   logic [DW-1:0] run_max [15] = '{5, 900, 900, 900, 1024, 1024, 1024, 1024, 2000, 2000, 2000, 2000, 2000, 2000, 2000};
   logic [DW-1:0] desc [15]    = '{2000, 1024, 900, 900, 900, 512, 300, 128, 64, 42, 33, 17, 7, 5, 1};

   bram_tree_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
      .CLK(CLK), .RSTn(RSTn), .i_wrt(i_wrt), .i_read(i_read), .i_data(i_data),
      .o_full(o_full), .o_empty(o_empty), .o_data(o_data)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mmax();
      int unsigned m = 0;
      foreach (mq[i]) if (mq[i] > m) m = mq[i];
      return m;
   endfunction

   function automatic void mpop();
      int j = 0;
      if (mq.size() == 0) return;
      foreach (mq[i]) if (mq[i] > mq[j]) j = i;
      mq.delete(j);
   endfunction

   // one-cycle request pulse, model update, then idle long enough for any operation to finish
   task automatic op(input logic w, input logic r, input logic [DW-1:0] d);
      @(negedge CLK);
      i_wrt = w;
      i_read = r;
      i_data = d;
      @(negedge CLK);
      i_wrt = 1'b0;
      i_read = 1'b0;
      if (w && (!r || mq.size() == 0)) begin
         if (mq.size() < QS) mq.push_back(d);
      end else if (r && !w) mpop();
      else if (r && w) begin
         mpop();
         mq.push_back(d);
      end
      repeat (24) @(negedge CLK);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_data"}, o_data, mmax());
      chk({tag, "_empty"}, o_empty, 32'(mq.size() == 0));
      chk({tag, "_full"}, o_full, 32'(mq.size() == QS));
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      RSTn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rst_empty", o_empty, 1);
         chk("rst_full", o_full, 0);
         chk("rst_data", o_data, 0);
      end
      for (int i = 0; i < 15; i++) begin
         op(1'b1, 1'b0, keys[i]);
         chk($sformatf("enq%0d_data", i), o_data, run_max[i]);
         chk($sformatf("enq%0d_empty", i), o_empty, 0);
         if (i == 4) chk("enq5_full", o_full, 0);
      end
      chk("fill_full", o_full, 1);
      op(1'b1, 1'b0, 7);
      chk("enq_full_data", o_data, 2000);
      chk("enq_full_full", o_full, 1);
      for (int i = 1; i <= 15; i++) begin
         op(1'b0, 1'b1, 0);
         chk($sformatf("deq%0d_data", i), o_data, i < 15 ? desc[i] : 0);
      end
      chk("drained_empty", o_empty, 1);
      op(1'b0, 1'b1, 0);
      chk("deq_empty_data", o_data, 0);
      chk("deq_empty_empty", o_empty, 1);
      op(1'b1, 1'b1, 321);
      chk("rep_as_enq_data", o_data, 321);
      op(1'b0, 1'b1, 0);
      chk("rep_as_enq_drain", o_empty, 1);
      for (int i = 0; i < 15; i++) op(1'b1, 1'b0, DW'($urandom_range(0, 1024)));
      chk_model("refill");
      for (int i = 0; i < 15; i++) begin
         op(1'b1, 1'b1, DW'($urandom_range(0, 1024)));
         chk($sformatf("rep%0d_data", i), o_data, mmax());
         chk($sformatf("rep%0d_full", i), o_full, 1);
      end
      for (int i = 0; i < 100; i++) begin
         case ($urandom_range(0, 2))
            0: op(1'b1, 1'b0, DW'($urandom_range(0, 1024)));
            1: op(1'b0, 1'b1, 0);
            default: op(1'b1, 1'b1, DW'($urandom_range(0, 1024)));
         endcase
         chk_model($sformatf("stress%0d", i));
      end
      while (mq.size() < QS) op(1'b1, 1'b0, DW'($urandom_range(0, 1024)));
      chk_model("prefull");
      @(negedge CLK);
      i_read = 1'b1;
      @(negedge CLK);
      i_read = 1'b0;
      repeat (3) @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);
      RSTn = 1'b0;
      mq.delete();
      chk("midrst_empty", o_empty, 1);
      chk("midrst_data", o_data, 0);
      chk("midrst_full", o_full, 0);
      op(1'b1, 1'b0, 77);
      chk("post_rst_enq", o_data, 77);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
